// File: rtl/motor_pkg.sv
// Shared types and constants for the H-bridge PWM drive.
package motor_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DEAD, FAULT} state_t;

    localparam logic DIR_FWD      = 1'b1;
    localparam logic DIR_REV      = 1'b0;
    localparam int   PWM_BITS_DEF = 8;
endpackage

// File: rtl/motor_pwm_drive_if.sv
// Speed/direction command channel from the steering controller.
interface motor_pwm_drive_if import motor_pkg::*; #(
    parameter int PWM_BITS = PWM_BITS_DEF
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_dir;
    logic [PWM_BITS-1:0] cmd_duty;

    modport master (output cmd_valid, cmd_dir, cmd_duty, input cmd_ready);
    modport slave  (input cmd_valid, cmd_dir, cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_pwm_drive_pwm_counter.sv
// Prescaler plus free-running PWM counter; period_wrap marks the cycle before count 0.
module pwm_counter #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                period_wrap
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_cnt;
    logic          tick;

    assign tick        = (pre_cnt == PW'(PRESCALE - 1));
    assign period_wrap = tick && (pwm_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/motor_pwm_drive.sv
// One H-bridge channel: command handshake, dead time on reversal, trip handling, PWM pins.
// Optional duty slew limiting is enabled by defining MOTOR_RAMP_EN.
module motor_pwm_drive import motor_pkg::*; #(
    parameter int PWM_BITS         = PWM_BITS_DEF,
    parameter int PRESCALE         = 16,
    parameter int DEAD_CYCLES      = 100000,
    parameter int RAMP_STEP_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    motor_pwm_drive_if.slave  cmd,
    input  logic              on_current,
    output logic              IN1,
    output logic              IN2,
    output logic              fault
);
    localparam int DW = $clog2(DEAD_CYCLES + 1);

    if (PRESCALE < 1 || DEAD_CYCLES < 1 || RAMP_STEP_CYCLES < 1) begin : g_bad_param
        $error("motor_pwm_drive: PRESCALE, DEAD_CYCLES and RAMP_STEP_CYCLES must be >= 1");
    end

    state_t              state, state_nxt;
    logic                dir_cur, dir_tgt;
    logic [PWM_BITS-1:0] duty_tgt, duty_cur, duty_act, pwm_cnt;
    logic [DW-1:0]       dead_cnt;
    logic                period_wrap, acc, hold, idle_zero, dead_done, pwm;

    pwm_counter #(.PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) u_pwm (
        .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt), .period_wrap(period_wrap)
    );

    assign cmd.cmd_ready = (state != DEAD);
    assign acc           = cmd.cmd_valid && cmd.cmd_ready;
    assign dead_done     = (dead_cnt == DW'(DEAD_CYCLES - 1));
    assign idle_zero     = (duty_tgt == '0) && (duty_cur == '0) && (duty_act == '0);
    assign hold          = (state_nxt == DEAD) || (state_nxt == FAULT);
    assign pwm           = (pwm_cnt < duty_act);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (acc && cmd.cmd_duty != '0)
                       state_nxt = (cmd.cmd_dir != dir_cur) ? DEAD : RUN;
            RUN:   if (acc && cmd.cmd_duty != '0 && cmd.cmd_dir != dir_cur) state_nxt = DEAD;
                   else if (idle_zero && !acc)                               state_nxt = IDLE;
            DEAD:  if (dead_done)  state_nxt = RUN;
            FAULT: if (on_current) state_nxt = DEAD;
            default: state_nxt = IDLE;
        endcase
        // A trip wins over any command or timer in the same cycle.
        if (!on_current) state_nxt = FAULT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dir_cur  <= DIR_FWD;
            dir_tgt  <= DIR_FWD;
            duty_tgt <= '0;
            duty_act <= '0;
            dead_cnt <= '0;
            IN1      <= 1'b0;
            IN2      <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                duty_tgt <= cmd.cmd_duty;
                dir_tgt  <= cmd.cmd_dir;
            end
            dead_cnt <= (state == DEAD) ? dead_cnt + 1'b1 : '0;
            if (state == DEAD && state_nxt == RUN) dir_cur <= dir_tgt;
            // duty_act only moves on a period boundary so pulses are never truncated.
            if (hold)             duty_act <= '0;
            else if (period_wrap) duty_act <= duty_cur;
            IN1   <= (state == RUN) && (dir_cur == DIR_FWD) && pwm;
            IN2   <= (state == RUN) && (dir_cur == DIR_REV) && pwm;
            fault <= (state == FAULT);
        end
    end

`ifdef MOTOR_RAMP_EN
    localparam int RW = $clog2(RAMP_STEP_CYCLES + 1);

    logic [RW-1:0] ramp_cnt;
    logic          ramp_step;

    assign ramp_step = (ramp_cnt == RW'(RAMP_STEP_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_cnt <= '0;
            duty_cur <= '0;
        end else if (hold) begin
            ramp_cnt <= '0;
            duty_cur <= '0;
        end else begin
            ramp_cnt <= ramp_step ? '0 : ramp_cnt + 1'b1;
            if (ramp_step) begin
                if (duty_cur < duty_tgt)      duty_cur <= duty_cur + 1'b1;
                else if (duty_cur > duty_tgt) duty_cur <= duty_cur - 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    duty_cur <= '0;
        else if (hold) duty_cur <= '0;
        else           duty_cur <= acc ? cmd.cmd_duty : duty_tgt;
    end
`endif
endmodule

// File: tb/tb_motor_pwm_drive.sv
// Scoreboard bench for motor_pwm_drive with shrunk timing parameters.
module tb_motor_pwm_drive;
    localparam int   PB = 4, PS = 2, DC = 40, RS = 8;
    localparam int   P  = PS * (1 << PB);
    localparam logic FWD = 1'b1, REV = 1'b0;
`ifdef MOTOR_RAMP_EN
    localparam int SETTLE = 2 * P + 16 * RS;
`else
    localparam int SETTLE = 2 * P;
`endif

    logic clk = 1'b0, rst_n = 1'b0, on_current = 1'b1;
    logic IN1, IN2, fault;
    int   n_vec = 0, n_err = 0, overlap = 0;

    motor_pwm_drive_if #(.PWM_BITS(PB)) cmd ();

    motor_pwm_drive #(.PWM_BITS(PB), .PRESCALE(PS), .DEAD_CYCLES(DC), .RAMP_STEP_CYCLES(RS)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .on_current(on_current),
        .IN1(IN1), .IN2(IN2), .fault(fault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (IN1 && IN2) overlap++;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    typedef struct { string tag; int val; } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop(input int got);
        exp_t e;
        if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
        else begin
            e = sb.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic cmp(input string tag, input int got, input int want);
        push(tag, want);
        pop(got);
    endtask

    task automatic send(input logic d, input int duty);
        int k = 0;
        @(negedge clk);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_dir   = d;
        cmd.cmd_duty  = duty[PB-1:0];
        while (!cmd.cmd_ready && k < 1000) begin @(negedge clk); k++; end
        chk("send_ready", int'(cmd.cmd_ready), 1);
        @(negedge clk);
        cmd.cmd_valid = 1'b0;
    endtask

    task automatic sample(input string tag, input int e1, input int e2);
        int h1 = 0, h2 = 0;
        push({tag, "_in1"}, e1);
        push({tag, "_in2"}, e2);
        repeat (P) begin
            @(negedge clk);
            if (IN1) h1++;
            if (IN2) h2++;
        end
        pop(h1);
        pop(h2);
    endtask

    task automatic pulse_len(output int len);
        int k = 0;
        len = 0;
        @(negedge clk);
        while (IN1 && k < 4 * P)  begin @(negedge clk); k++; end
        while (!IN1 && k < 4 * P) begin @(negedge clk); k++; end
        while (IN1 && len < 2 * P) begin len++; @(negedge clk); end
    endtask

    // Entered on the first negedge with the DUT already in dead time.
    task automatic dead_window(input string tag);
        int n = 0, hi = 0;
        push({tag, "_ready_lo"}, DC);
        push({tag, "_pins_hi"}, 0);
        while (!cmd.cmd_ready && n < 4 * DC) begin
            n++;
            if (n > 1 && (IN1 || IN2)) hi++;
            @(negedge clk);
        end
        if (IN1 || IN2) hi++;
        pop(n);
        pop(hi);
    endtask

    initial begin
        int len, k, hi;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_dir   = FWD;
        cmd.cmd_duty  = '0;
        repeat (3) @(negedge clk);
        cmp("rst_in1", int'(IN1), 0);
        cmp("rst_in2", int'(IN2), 0);
        cmp("rst_fault", int'(fault), 0);
        cmp("rst_ready", int'(cmd.cmd_ready), 1);
        rst_n = 1'b1;

        send(FWD, 4);
`ifndef MOTOR_RAMP_EN
        push("first_pulse", 8);
        pulse_len(len);
        pop(len);
`endif
        repeat (SETTLE) @(negedge clk);
        sample("fwd4", 8, 0);
        send(FWD, 8);
        repeat (SETTLE) @(negedge clk);
        sample("fwd8", 16, 0);

        send(REV, 8);
        dead_window("rev");
        repeat (SETTLE) @(negedge clk);
        sample("rev8", 0, 16);

        // Trip during RUN: fault and pins move one edge after the sampling edge.
        on_current = 1'b0;
        @(negedge clk);
        cmp("trip_fault_n", int'(fault), 0);
        @(negedge clk);
        cmp("trip_fault_n1", int'(fault), 1);
        cmp("trip_pins_n1", int'(IN1 || IN2), 0);
        hi = 0;
        repeat (8) begin @(negedge clk); if (IN1 || IN2) hi++; end
        cmp("trip_pins_hold", hi, 0);
        cmp("trip_ready", int'(cmd.cmd_ready), 1);
        on_current = 1'b1;
        @(negedge clk);
        dead_window("trip");
        repeat (SETTLE) @(negedge clk);
        sample("trip_resume", 0, 16);
        cmp("trip_fault_clr", int'(fault), 0);

        // Command accepted on the same edge as a trip: both must take effect.
        on_current    = 1'b0;
        cmd.cmd_valid = 1'b1;
        cmd.cmd_dir   = REV;
        cmd.cmd_duty  = 4'd12;
        @(negedge clk);
        cmd.cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        cmp("trip2_fault", int'(fault), 1);
        on_current = 1'b1;
        @(negedge clk);
        dead_window("trip2");
        repeat (SETTLE) @(negedge clk);
        sample("trip2_resume", 0, 24);

        send(REV, 0);
        repeat (SETTLE) @(negedge clk);
        sample("duty0", 0, 0);
        send(FWD, 15);
        dead_window("rev2fwd");
        repeat (SETTLE) @(negedge clk);
        sample("duty15", 30, 0);

        // Duty change mid-pulse must not cut the running pulse.
        k = 0;
        while (IN1 && k < 2 * P)  begin @(negedge clk); k++; end
        while (!IN1 && k < 4 * P) begin @(negedge clk); k++; end
        len = 0;
        while (IN1 && len < 2 * P) begin
            len++;
            if (len == 4) begin cmd.cmd_valid = 1'b1; cmd.cmd_dir = FWD; cmd.cmd_duty = 4'd2; end
            if (len == 5) cmd.cmd_valid = 1'b0;
            @(negedge clk);
        end
        cmp("mid_change_cur", len, 30);
`ifndef MOTOR_RAMP_EN
        pulse_len(len);
        cmp("mid_change_next", len, 4);
`endif

        k = 0;
        while (!IN1 && k < 4 * P) begin @(negedge clk); k++; end
        cmp("pre_rst_high", int'(IN1), 1);
        #2 rst_n = 1'b0;
        #1;
        cmp("arst_in1", int'(IN1), 0);
        cmp("arst_fault", int'(fault), 0);
        cmp("arst_ready", int'(cmd.cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        sample("post_rst", 0, 0);

`ifdef MOTOR_RAMP_EN
        send(FWD, 10);
        repeat (10 * RS + 3 * P) @(negedge clk);
        sample("ramp10", 20, 0);
`endif

        cmp("no_overlap", overlap, 0);
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/motor_pwm_drive.md
# motor_pwm_drive

- Drives one H-bridge channel of the rover from a speed/direction command:
  - generates the IN1/IN2 PWM pair;
  - inserts dead time on direction reversal;
  - obeys the over-current enable from the motor-protection block.
- Sits between the rover steering/search controller (command side) and the H-bridge pins, with one instance per motor.

## Interface
Parameters:
- PWM_BITS, 8, duty/counter width
- PRESCALE, 16, clk cycles per PWM count (≥1)
- DEAD_CYCLES, 100000, both-low interval on reversal/recovery (1 ms @ 100 MHz, ≥1)
- RAMP_STEP_CYCLES, 50000, clk cycles per ±1 duty step (used only with ramp)

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command can be accepted
- cmd_dir  in  1  1 = forward, 0 = reverse
- cmd_duty  in  PWM_BITS  target duty, 0 = stop
- on_current  in  1  enable from protection block, same clock domain, 0 = trip
- IN1  out  1  H-bridge forward input
- IN2  out  1  H-bridge reverse input
- fault  out  1  high while tripped

## Operation
- **Handshake:**
  - A command is accepted on a cycle with cmd_valid && cmd_ready.
  - cmd_ready = 0 only in DEAD; commands are accepted in FAULT.
  - An accepted command loads duty_tgt/dir_tgt.
- **PWM:**
  - A prescaler counts 0..PRESCALE-1 and ticks the PWM counter on wrap.
  - The PWM counter counts 0..2^PWM_BITS-1 and wraps to 0 (period boundary).
  - pwm = (pwm_cnt < duty_act). duty 0 gives constant low; max duty gives high for 255 of 256 counts.
  - duty_act loads from duty_cur only at a period boundary, so no partial pulses occur.
- **Steering:** RUN forward: IN1 = pwm, IN2 = 0. RUN reverse: IN1 = 0, IN2 = pwm. Both are low in all other states.
- **Invariant:** IN1 && IN2 is never true.
- **States and transitions:**
  - IDLE → RUN on acceptance with duty ≠ 0.
  - RUN → IDLE when duty_tgt = 0 and duty_act = 0.
  - RUN or IDLE → DEAD on acceptance with dir ≠ current dir and duty ≠ 0.
    - Entering DEAD zeroes duty_cur/duty_act and clears the dead counter.
    - DEAD → RUN in dir_tgt after DEAD_CYCLES.
  - Any state → FAULT when on_current = 0; this has priority over everything else.
    - FAULT holds outputs low and fault = 1.
    - When on_current returns to 1, FAULT → DEAD, then resumes the stored target.
- **Simultaneous events:** a command accepted in the same cycle as a trip is stored, and the state goes to FAULT.
- **Repeated commands:** a same-direction command during RUN changes only duty_tgt; no dead time is inserted.

## Timing
- **Reset values:** IN1 = IN2 = 0, fault = 0, cmd_ready = 1, state IDLE, dir forward, all duty values and counters 0.
- **Asynchronous reset:** asserting rst_n mid-operation forces the outputs low immediately.
- **Trip latency:** if on_current = 0 is sampled at edge N, IN1, IN2 and fault are updated at edge N+1 (all outputs registered).
- **Command latency:** duty_tgt updates one cycle after acceptance. The new duty reaches the pins at the first period boundary after duty_cur reaches it.
- **PWM period:** PRESCALE × 2^PWM_BITS clocks = 4096 clk (≈24.4 kHz) at the defaults.
- **Dead time:** exactly DEAD_CYCLES clocks with both pins low, followed by RUN on the next cycle.

## Configuration
- **MOTOR_RAMP_EN defined:**
  - duty_cur slews toward duty_tgt by ±1 every RAMP_STEP_CYCLES.
  - Ramping restarts from 0 after DEAD.
  - RUN → IDLE occurs only after ramp-down completes.
- **MOTOR_RAMP_EN undefined:** duty_cur = duty_tgt one cycle after acceptance, and RAMP_STEP_CYCLES is ignored.

## Structure
- **Package motor_pkg:**
  - state enum {IDLE, RUN, DEAD, FAULT}
  - DIR_FWD/DIR_REV constants
  - default PWM_BITS
- **Sub-module pwm_counter:**
  - contains the prescaler and PWM counter;
  - outputs pwm_cnt and a one-cycle period_wrap pulse.

## Test plan
- Reset, then forward with duty 64 → IN2 = 0 constantly; IN1 high for 1024 of each 4096 clocks. Without ramp, the first full pulse appears at the first period boundary.
- Forward 128, then reverse 128 → both pins low for exactly 100000 clocks; cmd_ready = 0 throughout; then IN2 pulses 2048 of 4096 clocks.
- on_current low for 10 cycles during RUN → pins low and fault = 1 at edge N+1. After release: DEAD for 100000 clocks, then the prior duty resumes.
- Duty 0 and duty 255 → constant low; high for 4080 of every 4096 clocks. A mid-period duty change takes effect only at the boundary.
- With MOTOR_RAMP_EN, 0 → 10 forward → duty_act reaches 10 after 10 × 50000 clocks, aligned to a period boundary. rst_n pulsed mid-ramp → pins low immediately and the reset values are restored.
- Assertion over all tests: never IN1 && IN2; no trip lost when it coincides with a command.
